// File: rtl/ipv4_rx_if.sv
// Stream and status bundle between the MAC-side source, ipv4_rx and the TCP receiver.
// Fixed at 16-bit beats; [15:8] is the earlier byte on the wire.
interface ipv4_rx_if;
    logic        valid_i;
    logic        start_i;
    logic        last_i;
    logic [15:0] data_i;
    logic        len_i;
    logic        valid_o;
    logic        start_o;
    logic        len_o;
    logic [15:0] data_o;
    logic        hdr_v_o;
    logic [31:0] src_ip_o;
    logic        drop_o;
    logic        trunc_o;

    modport slave (
        input  valid_i, start_i, last_i, data_i, len_i,
        output valid_o, start_o, len_o, data_o, hdr_v_o, src_ip_o, drop_o, trunc_o
    );

    modport master (
        output valid_i, start_i, last_i, data_i, len_i,
        input  valid_o, start_o, len_o, data_o, hdr_v_o, src_ip_o, drop_o, trunc_o
    );
endinterface

// File: rtl/ipv4_rx.sv
// IPv4 receive filter: validates a 20-byte option-less header addressed to LOCAL_IP and
// forwards exactly total_length-20 payload bytes as a registered TCP segment stream.
module ipv4_rx #(
    parameter int unsigned DATA_W   = 16,
    parameter logic [31:0] LOCAL_IP = 32'hC0A80102
) (
    input  logic        clk,
    input  logic        reset,
    ipv4_rx_if.slave    bus
);

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StHead  = 4'b0010,
        StData  = 4'b0100,
        StDrain = 4'b1000
    } state_e;

    state_e      state_q;
    logic [3:0]  hdr_cnt_q;
    logic [15:0] csum_q;
    logic [7:0]  ver_ihl_q;
    logic [15:0] tot_len_q;
    logic [13:0] frag_q;
    logic [7:0]  proto_q;
    logic [31:0] src_q;
    logic [15:0] dst_hi_q;
    logic [15:0] rem_q;
    logic        first_q;

    logic        valid_q;
    logic        start_q;
    logic        len_q;
    logic [15:0] data_q;
    logic        hdr_v_q;
    logic [31:0] src_ip_q;
    logic        drop_q;
    logic        trunc_q;

    logic [DATA_W-1:0] din;
    logic [16:0]       csum_sum;
    logic [15:0]       csum_next;
    logic              hdr_ok;
    logic [15:0]       pay_len;
    logic [1:0]        beat_bytes;
    logic [15:0]       take;
    logic [15:0]       rem_next;
    logic              len_out;
    logic              trunc_hit;

    assign din = bus.data_i;

    // Ones-complement accumulate with end-around carry; cannot carry twice.
    assign csum_sum  = {1'b0, csum_q} + {1'b0, din};
    assign csum_next = csum_sum[15:0] + {15'b0, csum_sum[16]};

    // Evaluated on header beat 9, so the low destination half comes straight from din.
    assign hdr_ok = (ver_ihl_q == 8'h45) && (proto_q == 8'd6) &&
                    ({dst_hi_q, din} == LOCAL_IP) && (frag_q == 14'd0) &&
                    (tot_len_q >= 16'd20) && (csum_next == 16'hFFFF);

    assign pay_len    = tot_len_q - 16'd20;
    assign beat_bytes = (bus.last_i && bus.len_i) ? 2'd1 : 2'd2;
    assign take       = (rem_q == 16'd1) ? 16'd1 : 16'd2;
    assign rem_next   = rem_q - take;
    assign len_out    = (rem_q == 16'd1) || (bus.last_i && bus.len_i);
    assign trunc_hit  = bus.last_i && (rem_q > {14'b0, beat_bytes});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            hdr_cnt_q <= 4'd0;
            csum_q    <= 16'd0;
            ver_ihl_q <= 8'd0;
            tot_len_q <= 16'd0;
            frag_q    <= 14'd0;
            proto_q   <= 8'd0;
            src_q     <= 32'd0;
            dst_hi_q  <= 16'd0;
            rem_q     <= 16'd0;
            first_q   <= 1'b0;
            valid_q   <= 1'b0;
            start_q   <= 1'b0;
            len_q     <= 1'b0;
            data_q    <= 16'd0;
            hdr_v_q   <= 1'b0;
            src_ip_q  <= 32'd0;
            drop_q    <= 1'b0;
            trunc_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            start_q <= 1'b0;
            len_q   <= 1'b0;
            hdr_v_q <= 1'b0;
            drop_q  <= 1'b0;
            trunc_q <= 1'b0;

            if (bus.valid_i) begin
                if (bus.start_i) begin
                    // A start beat always restarts the header, silently dropping any datagram
                    // in flight; it is header beat 0 itself.
                    ver_ihl_q <= din[15:8];
                    csum_q    <= din;
                    if (bus.last_i) begin
                        state_q   <= StIdle;
                        hdr_cnt_q <= 4'd0;
                        drop_q    <= 1'b1;
                    end else begin
                        state_q   <= StHead;
                        hdr_cnt_q <= 4'd1;
                    end
                end else begin
                    unique case (state_q)
                        StIdle: begin
                        end

                        StHead: begin
                            csum_q    <= csum_next;
                            hdr_cnt_q <= hdr_cnt_q + 4'd1;
                            case (hdr_cnt_q)
                                4'd1:    tot_len_q      <= din;
                                4'd3:    frag_q         <= din[13:0];
                                4'd4:    proto_q        <= din[7:0];
                                4'd6:    src_q[31:16]   <= din;
                                4'd7:    src_q[15:0]    <= din;
                                4'd8:    dst_hi_q       <= din;
                                default: begin
                                end
                            endcase
                            if (bus.last_i) begin
                                state_q   <= StIdle;
                                hdr_cnt_q <= 4'd0;
                                drop_q    <= 1'b1;
                            end else if (hdr_cnt_q == 4'd9) begin
                                hdr_cnt_q <= 4'd0;
                                if (hdr_ok) begin
                                    hdr_v_q  <= 1'b1;
                                    src_ip_q <= src_q;
                                    rem_q    <= pay_len;
                                    first_q  <= 1'b1;
                                    state_q  <= (pay_len == 16'd0) ? StDrain : StData;
                                end else begin
                                    drop_q  <= 1'b1;
                                    state_q <= StDrain;
                                end
                            end
                        end

                        StData: begin
                            valid_q <= 1'b1;
                            start_q <= first_q;
                            first_q <= 1'b0;
                            len_q   <= len_out;
                            // The byte past the IP total length is padding; never expose it.
                            data_q  <= {din[15:8], len_out ? 8'h00 : din[7:0]};
                            trunc_q <= trunc_hit;
                            if (bus.last_i) begin
                                rem_q   <= 16'd0;
                                state_q <= StIdle;
                            end else begin
                                rem_q <= rem_next;
                                if (rem_next == 16'd0) begin
                                    state_q <= StDrain;
                                end
                            end
                        end

                        StDrain: begin
                            if (bus.last_i) begin
                                state_q <= StIdle;
                            end
                        end

                        default: begin
                            state_q <= StIdle;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.valid_o  = valid_q;
    assign bus.start_o  = start_q;
    assign bus.len_o    = len_q;
    assign bus.data_o   = data_q;
    assign bus.hdr_v_o  = hdr_v_q;
    assign bus.src_ip_o = src_ip_q;
    assign bus.drop_o   = drop_q;
    assign bus.trunc_o  = trunc_q;

endmodule

// File: tb/tb_ipv4_rx.sv
// Scoreboard bench for ipv4_rx: datagrams are built with real checksums, expected beats and
// header events are queued as stimulus is driven and matched as the DUT emits them.
module tb_ipv4_rx;
    localparam logic [31:0] LOCAL_IP = 32'hC0A80102;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ipv4_rx_if bus ();

    ipv4_rx #(
        .DATA_W   (16),
        .LOCAL_IP (LOCAL_IP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic        start;
        logic        len;
        logic        trunc;
        int          cyc;
    } beat_t;

    typedef struct {
        logic        is_hdr;
        logic [31:0] src;
        int          cyc;
    } evt_t;

    beat_t exp_beats[$];
    evt_t  exp_evts[$];
    beat_t mb;
    evt_t  me;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.valid_o) begin
                if (exp_beats.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    mb = exp_beats.pop_front();
                    check("data_o", {16'd0, bus.data_o}, {16'd0, mb.data});
                    check("start_o", {31'd0, bus.start_o}, {31'd0, mb.start});
                    check("len_o", {31'd0, bus.len_o}, {31'd0, mb.len});
                    check("trunc_o", {31'd0, bus.trunc_o}, {31'd0, mb.trunc});
                    check("beat_cycle", cyc, mb.cyc);
                end
            end else if (bus.start_o || bus.trunc_o) begin
                check("stray_start_trunc", {30'd0, bus.start_o, bus.trunc_o}, 32'd0);
            end
            if (bus.hdr_v_o || bus.drop_o) begin
                if (exp_evts.size() == 0) begin
                    check("unexpected_event", {30'd0, bus.hdr_v_o, bus.drop_o}, 32'd0);
                end else begin
                    me = exp_evts.pop_front();
                    check("event_kind", {30'd0, bus.hdr_v_o, bus.drop_o},
                          me.is_hdr ? 32'd2 : 32'd1);
                    if (me.is_hdr) check("src_ip_o", bus.src_ip_o, me.src);
                    check("event_cycle", cyc, me.cyc);
                end
            end
        end
    end

    logic [15:0] pkt[$];
    logic [7:0]  pay[$];
    logic        pkt_odd;
    logic [15:0] pkt_tl;
    logic [31:0] pkt_src;
    bit          pkt_acc;

    function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    // Header plus the bytes currently in pay[].
    task automatic build(input logic [15:0] tl, input logic [7:0] proto, input logic [31:0] src,
                         input logic [31:0] dst, input logic [15:0] frag, input bit corrupt);
        logic [15:0] h[10];
        logic [15:0] s;
        h = '{16'h4500, tl, 16'h1234, frag, {8'h40, proto}, 16'h0000,
              src[31:16], src[15:0], dst[31:16], dst[15:0]};
        s = 16'h0000;
        for (int i = 0; i < 10; i++) s = oc_add(s, h[i]);
        h[5] = ~s;
        if (corrupt) h[5] = h[5] ^ 16'h00FF;
        pkt.delete();
        for (int i = 0; i < 10; i++) pkt.push_back(h[i]);
        for (int i = 0; i < pay.size(); i += 2)
            pkt.push_back({pay[i], (i + 1 < pay.size()) ? pay[i+1] : 8'h00});
        pkt_odd = pay.size() % 2 == 1;
        pkt_tl  = tl;
        pkt_src = src;
        pkt_acc = (proto == 8'd6) && (dst == LOCAL_IP) && (frag[13:0] == 14'd0) &&
                  (tl >= 16'd20) && !corrupt;
    endtask

    task automatic drive(input logic [15:0] d, input logic st, input logic la, input logic ln,
                         input int gap, output int c);
        repeat (gap) begin
            bus.valid_i = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.valid_i = 1'b1;
        bus.start_i = st;
        bus.last_i  = la;
        bus.len_i   = ln;
        bus.data_i  = d;
        c = cyc + 1;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.start_i = 1'b0;
        bus.last_i  = 1'b0;
    endtask

    // phase: 0 header, 1 payload, 2 draining, 3 done
    task automatic send_pkt(input int gap, input int upto, input bit model);
        int    phase;
        int    rem;
        int    c;
        int    nb;
        logic  la;
        logic  ln;
        beat_t b;
        evt_t  e;
        phase = 0;
        rem   = 0;
        for (int i = 0; i < pkt.size() && i < upto; i++) begin
            la = (i == pkt.size() - 1);
            ln = la && pkt_odd;
            drive(pkt[i], i == 0, la, ln, gap, c);
            if (model) begin
                case (phase)
                    0: begin
                        if (la || i == 9) begin
                            e.is_hdr = !la && pkt_acc;
                            e.src    = pkt_src;
                            e.cyc    = c;
                            exp_evts.push_back(e);
                            rem   = int'(pkt_tl) - 20;
                            phase = la ? 3 : (!pkt_acc || rem == 0) ? 2 : 1;
                        end
                    end
                    1: begin
                        nb      = (la && ln) ? 1 : 2;
                        b.len   = (rem == 1) || (la && ln);
                        b.data  = b.len ? {pkt[i][15:8], 8'h00} : pkt[i];
                        b.start = (i == 10);
                        b.trunc = la && rem > nb;
                        b.cyc   = c;
                        exp_beats.push_back(b);
                        rem   = rem - ((rem < 2) ? rem : 2);
                        phase = la ? 3 : (rem == 0) ? 2 : 1;
                    end
                    2: if (la) phase = 3;
                    default: begin
                    end
                endcase
            end
        end
    endtask

    task automatic idle(input int n);
        bus.valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, bus.valid_o}, 32'd0);
        check({tag, "_pulses"}, {29'd0, bus.hdr_v_o, bus.drop_o, bus.trunc_o}, 32'd0);
        check({tag, "_data"}, {16'd0, bus.data_o}, 32'd0);
        check({tag, "_src_ip"}, bus.src_ip_o, 32'd0);
    endtask

    task automatic good_pkt(input logic [31:0] src);
        pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        build(16'h0018, 8'd6, src, LOCAL_IP, 16'h0000, 1'b0);
    endtask

    int dummy;

    initial begin
        reset       = 1'b1;
        bus.valid_i = 1'b0;
        bus.start_i = 1'b0;
        bus.last_i  = 1'b0;
        bus.len_i   = 1'b0;
        bus.data_i  = 16'h0000;
        repeat (3) @(posedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // Good datagram, back to back beats
        good_pkt(32'h0A000001);
        send_pkt(0, 1000, 1'b1);
        idle(3);

        // Corrupted checksum: drop, nothing forwarded
        good_pkt(32'h0A000002);
        build(16'h0018, 8'd6, 32'h0A000002, LOCAL_IP, 16'h0000, 1'b1);
        send_pkt(0, 1000, 1'b1);
        idle(3);

        // Short total length with Ethernet padding
        pay.delete();
        pay.push_back(8'hAA);
        pay.push_back(8'hBB);
        pay.push_back(8'hCC);
        for (int i = 0; i < 25; i++) pay.push_back(8'h5A);
        build(16'h0017, 8'd6, 32'h0A000003, LOCAL_IP, 16'h0000, 1'b0);
        send_pkt(0, 1000, 1'b1);
        idle(3);

        // Truncated: total length 32 but only 4 payload bytes arrive
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        build(16'h0020, 8'd6, 32'h0A000004, LOCAL_IP, 16'h0000, 1'b0);
        send_pkt(0, 1000, 1'b1);
        idle(3);

        // Restart at header beat 5, then a good datagram
        good_pkt(32'h0A000005);
        send_pkt(0, 5, 1'b0);
        good_pkt(32'h0A000006);
        send_pkt(0, 1000, 1'b1);
        idle(3);

        // valid_i every other cycle
        good_pkt(32'h0A000007);
        send_pkt(1, 1000, 1'b1);
        idle(3);

        // Wrong destination, MF set, wrong protocol
        pay = '{8'h01, 8'h02};
        build(16'h0016, 8'd6, 32'h0A000008, 32'hC0A80103, 16'h0000, 1'b0);
        send_pkt(0, 1000, 1'b1);
        idle(2);
        build(16'h0016, 8'd6, 32'h0A000009, LOCAL_IP, 16'h2000, 1'b0);
        send_pkt(0, 1000, 1'b1);
        idle(2);
        build(16'h0016, 8'd17, 32'h0A00000A, LOCAL_IP, 16'h0000, 1'b0);
        send_pkt(0, 1000, 1'b1);
        idle(2);

        // Zero-length payload: accepted, the padding beat is swallowed
        pay = '{8'hEE, 8'hEE};
        build(16'h0014, 8'd6, 32'h0A00000B, LOCAL_IP, 16'h0000, 1'b0);
        send_pkt(0, 1000, 1'b1);
        idle(2);

        // last_i inside the header: drop, then stray beats must be ignored in idle
        good_pkt(32'h0A00000C);
        pkt = pkt[0:3];
        send_pkt(0, 1000, 1'b1);
        drive(16'h1111, 1'b0, 1'b0, 1'b0, 0, dummy);
        drive(16'h2222, 1'b0, 1'b1, 1'b0, 0, dummy);
        idle(2);

        // Reset in the middle of a header: no pulses, outputs cleared, next datagram clean
        good_pkt(32'h0A00000D);
        send_pkt(0, 6, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        check_quiet("midreset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        good_pkt(32'h0A00000E);
        send_pkt(0, 1000, 1'b1);
        idle(5);

        check("beats_left", exp_beats.size(), 32'd0);
        check("events_left", exp_evts.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
